// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage. Runs loads/stores over a
// single-outstanding req/ack data port, aligns/extends load data, stalls
// upstream while an access is pending and registers the MEM/WB fence.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_ex,
    input  logic [31:0] alu_res_ex,
    input  logic [31:0] store_data_ex,
    input  logic [2:0]  mem_width_ex,
    input  logic        MemToReg_ex,
    input  logic        MemWrite_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  rdn_ex,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        valid_wb,
    output logic        RegWrite_wb,
    output logic [4:0]  rdn_wb,
    output logic [31:0] result_wb,
    output logic        mem_err_wb
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]  r_state;
    logic        r_req;
    logic        r_we;
    logic [29:0] r_word;
    logic [1:0]  r_lane;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_width;
    logic [4:0]  r_rdn;
    logic        r_regwrite;

    logic        r_valid_wb;
    logic        r_regwrite_wb;
    logic [4:0]  r_rdn_wb;
    logic [31:0] r_result_wb;
    logic        r_err_wb;

    logic        w_is_mem;
    logic        w_bad_width;
    logic        w_misalign;
    logic        w_fault;
    logic        w_accept;

    // Byte enables: one lane for bytes, two adjacent lanes for halves
    function automatic logic [3:0] f_be(input logic [2:0] width, input logic [1:0] lane);
        case (width[1:0])
            2'b00:   f_be = 4'b0001 << lane;
            2'b01:   f_be = 4'b0011 << lane;
            default: f_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane so the memory can pick any
    function automatic logic [31:0] f_wdata(input logic [2:0] width, input logic [31:0] data);
        case (width[1:0])
            2'b00:   f_wdata = {4{data[7:0]}};
            2'b01:   f_wdata = {2{data[15:0]}};
            default: f_wdata = data;
        endcase
    endfunction

    // Pick the addressed byte/half from the load word and extend it
    function automatic logic [31:0] f_load(input logic [2:0] width, input logic [1:0] lane,
                                           input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (width)
            3'b000:  f_load = {{24{b[7]}}, b};
            3'b100:  f_load = {24'd0, b};
            3'b001:  f_load = {{16{h[15]}}, h};
            3'b101:  f_load = {16'd0, h};
            default: f_load = rdata;
        endcase
    endfunction

    // Classify the EX instruction: memory op, fault, or accepted access
    always_comb begin
        w_is_mem    = valid_ex & (MemToReg_ex | MemWrite_ex);
        w_bad_width = (mem_width_ex == 3'b011) | (mem_width_ex == 3'b110) |
                      (mem_width_ex == 3'b111);
        w_misalign  = ((mem_width_ex[1:0] == 2'b01) & alu_res_ex[0]) |
                      ((mem_width_ex == 3'b010) & (alu_res_ex[1:0] != 2'b00));
        w_fault     = w_bad_width | w_misalign;
        w_accept    = (r_state == S_IDLE) & w_is_mem & ~w_fault;
        stall_mem   = ~rst & (w_accept | ((r_state == S_BUSY) & ~dmem_ack));
    end

    // FSM and registered bus outputs; held stable for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_word     <= '0;
            r_lane     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_width    <= '0;
            r_rdn      <= '0;
            r_regwrite <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_state    <= S_BUSY;
                r_req      <= 1'b1;
                r_we       <= MemWrite_ex;
                r_word     <= alu_res_ex[31:2];
                r_lane     <= alu_res_ex[1:0];
                r_be       <= f_be(mem_width_ex, alu_res_ex[1:0]);
                r_wdata    <= f_wdata(mem_width_ex, store_data_ex);
                r_width    <= mem_width_ex;
                r_rdn      <= rdn_ex;
                r_regwrite <= RegWrite_ex & ~MemWrite_ex & (rdn_ex != 5'd0);
            end
        end else if (dmem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end
    end

    // MEM/WB fence: pass-through, fault retire, or access completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_wb    <= 1'b0;
            r_regwrite_wb <= 1'b0;
            r_rdn_wb      <= '0;
            r_result_wb   <= '0;
            r_err_wb      <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_valid_wb <= dmem_ack;
            if (dmem_ack) begin
                r_regwrite_wb <= r_regwrite;
                r_rdn_wb      <= r_rdn;
                r_result_wb   <= r_we ? {r_word, r_lane} : f_load(r_width, r_lane, dmem_rdata);
                r_err_wb      <= 1'b0;
            end
        end else if (valid_ex & ~w_accept) begin
            // Any memory op that was not accepted here is a faulted one
            r_valid_wb    <= 1'b1;
            r_regwrite_wb <= RegWrite_ex & ~w_is_mem & (rdn_ex != 5'd0);
            r_rdn_wb      <= rdn_ex;
            r_result_wb   <= alu_res_ex;
            r_err_wb      <= w_is_mem;
        end else begin
            r_valid_wb <= 1'b0;
        end
    end

    assign dmem_req    = r_req;
    assign dmem_we     = r_we;
    assign dmem_addr   = {r_word, 2'b00};
    assign dmem_be     = r_be;
    assign dmem_wdata  = r_wdata;
    assign valid_wb    = r_valid_wb;
    assign RegWrite_wb = r_regwrite_wb;
    assign rdn_wb      = r_rdn_wb;
    assign result_wb   = r_result_wb;
    assign mem_err_wb  = r_err_wb;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, hand-written reset sequences and
// randomized operations checked against a spec-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ex;
    logic [31:0] alu_res_ex;
    logic [31:0] store_data_ex;
    logic [2:0]  mem_width_ex;
    logic        MemToReg_ex, MemWrite_ex, RegWrite_ex;
    logic [4:0]  rdn_ex;
    logic        stall_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        valid_wb, RegWrite_wb, mem_err_wb;
    logic [4:0]  rdn_wb;
    logic [31:0] result_wb;

    int checks = 0;
    int failures = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .valid_ex(valid_ex), .alu_res_ex(alu_res_ex),
        .store_data_ex(store_data_ex), .mem_width_ex(mem_width_ex),
        .MemToReg_ex(MemToReg_ex), .MemWrite_ex(MemWrite_ex), .RegWrite_ex(RegWrite_ex),
        .rdn_ex(rdn_ex), .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_wb(valid_wb),
        .RegWrite_wb(RegWrite_wb), .rdn_wb(rdn_wb), .result_wb(result_wb),
        .mem_err_wb(mem_err_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mtr, mw, rw;
        logic [2:0]  w;
        logic [31:0] addr, sdata, rdata;
        logic [4:0]  rdn;
        int          dly;
        logic        e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
        logic        e_chkres;
        logic        e_rw;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mtr, input logic mw, input logic rw,
                                input logic [2:0] w, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                input logic [4:0] rdn, input int dly, input logic e_err,
                                input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic [31:0] e_res, input logic e_chkres,
                                input logic e_rw);
        vec_t v;
        v.mtr = mtr; v.mw = mw; v.rw = rw; v.w = w; v.addr = addr; v.sdata = sdata;
        v.rdata = rdata; v.rdn = rdn; v.dly = dly; v.e_err = e_err; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_res = e_res; v.e_chkres = e_chkres; v.e_rw = e_rw;
        return v;
    endfunction

    // Reference model: expected results from the access rules, in arithmetic form
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        int     size, lane;
        logic [31:0] mask, val;
        logic   is_mem;
        r = v;
        is_mem = v.mtr | v.mw;
        size = (v.w[1:0] == 2'b00) ? 1 : (v.w[1:0] == 2'b01) ? 2 : 4;
        lane = int'(v.addr[1:0]);
        r.e_err = is_mem && ((v.w == 3'd3) || (v.w == 3'd6) || (v.w == 3'd7) ||
                             (size == 2 && lane % 2 != 0) || (size == 4 && lane != 0));
        r.e_be = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << lane);
        r.e_wdata = (size == 1) ? v.sdata[7:0] * 32'h0101_0101 :
                    (size == 2) ? v.sdata[15:0] * 32'h0001_0001 : v.sdata;
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        val  = (v.rdata >> (8 * lane)) & mask;
        if (!v.w[2] && size < 4 && (val & ((mask >> 1) + 32'd1)) != 0) val = val | ~mask;
        if (!is_mem) begin
            r.e_res = v.addr; r.e_chkres = 1'b1; r.e_rw = v.rw && v.rdn != 0;
        end else if (r.e_err) begin
            r.e_res = 32'd0; r.e_chkres = 1'b0; r.e_rw = 1'b0;
        end else if (v.mw) begin
            r.e_res = 32'd0; r.e_chkres = 1'b0; r.e_rw = 1'b0;
        end else begin
            r.e_res = val; r.e_chkres = 1'b1; r.e_rw = v.rw && v.rdn != 0;
        end
        return r;
    endfunction

    // Apply one EX instruction and follow it to WB; entered and left at posedge+1
    task automatic do_op(input vec_t v);
        logic good;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        valid_ex = 1'b1; alu_res_ex = v.addr; store_data_ex = v.sdata;
        mem_width_ex = v.w; MemToReg_ex = v.mtr; MemWrite_ex = v.mw;
        RegWrite_ex = v.rw; rdn_ex = v.rdn; dmem_ack = 1'b0;
        good = (v.mtr | v.mw) & ~v.e_err;
        #1;
        chk("stall_accept", stall_mem, good);
        @(posedge clk); #1;
        if (!good) begin
            chk("pass_valid", valid_wb, 1'b1);
            chk("pass_err", mem_err_wb, v.e_err);
            chk("pass_regwrite", RegWrite_wb, v.e_rw);
            chk("pass_rdn", rdn_wb, v.rdn);
            if (v.e_chkres) chk("pass_result", result_wb, v.e_res);
            chk("pass_noreq", dmem_req, 1'b0);
            valid_ex = 1'b0;
            return;
        end
        chk("bubble_valid", valid_wb, 1'b0);
        chk("req", dmem_req, 1'b1);
        chk("we", dmem_we, v.mw);
        chk("addr", dmem_addr, {v.addr[31:2], 2'b00});
        chk("be", dmem_be, v.e_be);
        if (v.mw) chk("wdata", dmem_wdata, v.e_wdata);
        s_addr = dmem_addr; s_be = dmem_be; s_wdata = dmem_wdata;
        for (int i = 0; i < v.dly; i++) begin
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            #1;
            chk("stall_wait", stall_mem, 1'b1);
            @(posedge clk); #1;
            chk("wait_req", dmem_req, 1'b1);
            chk("wait_addr", dmem_addr, s_addr);
            chk("wait_be", dmem_be, s_be);
            chk("wait_wdata", dmem_wdata, s_wdata);
            chk("wait_valid", valid_wb, 1'b0);
        end
        dmem_ack = 1'b1; dmem_rdata = v.rdata;
        #1;
        chk("stall_ack", stall_mem, 1'b0);
        @(posedge clk); #1;
        dmem_ack = 1'b0; valid_ex = 1'b0;
        chk("done_valid", valid_wb, 1'b1);
        chk("done_err", mem_err_wb, 1'b0);
        chk("done_regwrite", RegWrite_wb, v.e_rw);
        chk("done_rdn", rdn_wb, v.rdn);
        if (v.e_chkres) chk("done_result", result_wb, v.e_res);
        chk("done_req", dmem_req, 1'b0);
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        // mtr mw rw w addr sdata rdata rdn dly | err be wdata res chkres rw
        tbl[0] = mk(0,0,1,3'b000,32'h0000_1234,0,0,5,0, 0,4'h0,0,32'h0000_1234,1,1);
        tbl[1] = mk(1,0,1,3'b000,32'h0000_0103,0,32'h80FF_FFFF,7,0, 0,4'b1000,0,32'hFFFF_FF80,1,1);
        tbl[2] = mk(0,1,0,3'b001,32'h0000_0202,32'hABCD_5678,0,0,3, 0,4'b1100,32'h5678_5678,0,0,0);
        tbl[3] = mk(1,0,1,3'b101,32'h0000_0012,0,32'hF00D_0000,3,1, 0,4'b1100,0,32'h0000_F00D,1,1);
        tbl[4] = mk(1,0,1,3'b010,32'h0000_0040,0,32'hDEAD_BEEF,0,2, 0,4'b1111,0,32'hDEAD_BEEF,1,0);
        tbl[5] = mk(1,0,1,3'b010,32'h0000_0101,0,0,9,0, 1,4'h0,0,0,0,0);
        tbl[6] = mk(1,0,1,3'b011,32'h0000_0100,0,0,9,0, 1,4'h0,0,0,0,0);
        tbl[7] = mk(0,1,0,3'b000,32'h0000_0301,32'h1122_33A5,0,0,0, 0,4'b0010,32'hA5A5_A5A5,0,0,0);
        tbl[8] = mk(1,0,1,3'b100,32'h0000_0002,0,32'h129A_5678,4,0, 0,4'b0100,0,32'h0000_009A,1,1);
        tbl[9] = mk(1,0,1,3'b001,32'h0000_0006,0,32'h8001_0000,6,1, 0,4'b1100,0,32'hFFFF_8001,1,1);

        rst = 1'b1; valid_ex = 1'b0; alu_res_ex = '0; store_data_ex = '0;
        mem_width_ex = '0; MemToReg_ex = 1'b0; MemWrite_ex = 1'b0; RegWrite_ex = 1'b0;
        rdn_ex = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        #3;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", dmem_be, 4'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_valid", valid_wb, 1'b0);
        chk("rst_regwrite", RegWrite_wb, 1'b0);
        chk("rst_rdn", rdn_wb, 5'd0);
        chk("rst_result", result_wb, 32'd0);
        chk("rst_err", mem_err_wb, 1'b0);
        valid_ex = 1'b1; MemToReg_ex = 1'b1; mem_width_ex = 3'b010;
        #1;
        chk("rst_stall", stall_mem, 1'b0);
        valid_ex = 1'b0; MemToReg_ex = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) do_op(tbl[i]);

        // Reset in the second BUSY cycle aborts the access immediately
        valid_ex = 1'b1; MemToReg_ex = 1'b1; MemWrite_ex = 1'b0; RegWrite_ex = 1'b1;
        mem_width_ex = 3'b010; alu_res_ex = 32'h0000_0080; rdn_ex = 5'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_req_before", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_req", dmem_req, 1'b0);
        chk("abort_valid", valid_wb, 1'b0);
        chk("abort_stall", stall_mem, 1'b0);
        valid_ex = 1'b0; MemToReg_ex = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(model(mk(1,0,1,3'b010,32'h0000_0084,0,32'hCAFE_F00D,11,1, 0,0,0,0,0,0)));

        // Randomized back-to-back operations against the reference model
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            rv.mtr = (kind == 1); rv.mw = (kind == 2); rv.rw = 1'(($urandom & 3) != 0);
            rv.w = 3'($urandom_range(0, 7));
            rv.addr = $urandom;
            if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
            rv.sdata = $urandom; rv.rdata = $urandom;
            rv.rdn = 5'($urandom_range(0, 31));
            rv.dly = int'($urandom_range(0, 3));
            do_op(model(rv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32 five-stage pipeline. It sits directly downstream of the execute stage and upstream of write-back. It consumes the EX-stage result and control flags, performs loads and stores over a single-outstanding req/ack data-memory port, and aligns and extends load data. It drives a stall to the hazard logic while an access is pending, and registers the MEM/WB pipe fence.

## Interface
Parameters: none. Data and address widths are fixed at 32.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `valid_ex`  in  1  EX holds a real instruction (0 = bubble)
- `alu_res_ex`  in  32  ALU result; this is the effective address for loads/stores
- `store_data_ex`  in  32  rs2 value for stores
- `mem_width_ex`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `MemToReg_ex`, `MemWrite_ex`, `RegWrite_ex`  in  1 each  EX control flags
- `rdn_ex`  in  5  destination register number
- `stall_mem`  out  1  freeze IF/ID/EX; EX inputs must stay stable while high
- `dmem_req`  out  1  bus request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word address; bits [1:0] are always 0
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_ack`  in  1  access complete; `dmem_rdata` is valid in the same cycle
- `dmem_rdata`  in  32  load word
- `valid_wb`  out  1  WB register holds a retiring instruction
- `RegWrite_wb`  out  1  register-file write enable
- `rdn_wb`  out  5  destination register
- `result_wb`  out  32  ALU result or extended load data
- `mem_err_wb`  out  1  misaligned access or illegal width

## Operation
- FSM has two states, IDLE and BUSY. Reset enters IDLE.
- **IDLE, no memory op:** an instruction with `valid_ex`=1 and `MemToReg_ex`=`MemWrite_ex`=0 is passed through to WB on the next edge.
  - `result_wb` = `alu_res_ex`.
  - `RegWrite_wb` = `RegWrite_ex` && `rdn_ex`≠0.
  - `stall_mem` stays 0.
- **IDLE, memory op:** the access is first checked.
  - Misaligned cases: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Illegal width: 011, 110, 111.
- **IDLE, faulted op:** no bus access is made. The instruction retires next edge with `mem_err_wb`=1 and `RegWrite_wb`=0. `stall_mem`=0.
- **IDLE, good op:** `stall_mem`=1 this cycle. On the edge, the FSM latches addr, be, wdata, we, width, rdn and RegWrite, then moves to BUSY. `valid_wb` goes 0, inserting a bubble.
- **BUSY:**
  - `dmem_req`=1 with all bus outputs held stable.
  - `stall_mem` = !`dmem_ack`.
  - On `dmem_ack`, the next edge writes the WB register (`valid_wb`=1) and returns to IDLE.
  - Stores retire with `RegWrite_wb`=0.
- **Byte enables:** B → 4'b0001<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111.
- **Store data:** B → {4{byte}}; H → {2{half}}; W → word.
- **Load extraction:** lane = addr[1:0].
  - B/BU: `rdata[8*lane+:8]`.
  - H/HU: `rdata[16*addr[1]+:16]`.
  - B and H sign-extend; BU and HU zero-extend.
- `dmem_ack` in IDLE is ignored.
- EX inputs are ignored in BUSY; upstream holds them via `stall_mem`.
- An asynchronous `rst` mid-access aborts it: FSM returns to IDLE and `dmem_req` drops at once. The memory must tolerate an abandoned request.

## Timing
- **Reset values:** `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0, `valid_wb`=0, `RegWrite_wb`=0, `rdn_wb`=0, `result_wb`=0, `mem_err_wb`=0.
- `stall_mem` is combinational. It reads 0 while `rst` is high.
- Non-memory op and faulted memory op: 1 cycle EX→WB, no stall.
- Memory op: cycle 0 accept (stall=1); cycle 1 onward `dmem_req`=1.
  - Ack in cycle k (k≥1) → WB valid after edge k, stall low in cycle k.
  - Minimum 2 cycles per access, 1 stall cycle.
- `valid_wb` is 0 for every cycle in which `stall_mem` was 1 at the preceding edge.
- Back-to-back memory ops: the second op is accepted in the ack cycle+1 (IDLE). There is no zero-gap issue.
- All bus outputs are registered and glitch-free.

## Test plan
- **ALU pass-through:** `valid_ex`=1, `RegWrite_ex`=1, `rdn_ex`=5, `alu_res_ex`=0x1234 → next cycle `valid_wb`=1, `rdn_wb`=5, `result_wb`=0x1234, no stall.
- **LB sign-extend:** addr 0x103, `dmem_rdata`=0x80FF_FFFF, ack on first req cycle → `dmem_addr`=0x100, `dmem_be`=4'b1000, exactly one stall cycle, `result_wb`=0xFFFF_FF80.
- **SH:** addr 0x202, data 0xABCD_5678, ack delayed 3 cycles → `dmem_we`=1, `dmem_be`=4'b1100, `dmem_wdata`=0x5678_5678. Bus outputs are stable for the 3 wait cycles, `stall_mem` stays 1 until the ack cycle, and `RegWrite_wb`=0.
- **LHU and LW:** LHU at 0x12 with rdata 0xF00D_0000 → 0x0000_F00D. LW to `rdn_ex`=0 → `RegWrite_wb`=0.
- **Faults:** LW at 0x101 → no `dmem_req`, `mem_err_wb`=1, `RegWrite_wb`=0, no stall. funct3=3'b011 behaves the same.
- **Reset mid-access:** assert `rst` in the 2nd BUSY cycle → `dmem_req` drops immediately and `valid_wb`=0. After release, a new LW completes normally.
